// File: rtl/single_divide_s_v_serial.sv
// Scalar-over-vector single-precision divide. One shared single_divide is fed one
// element per cycle; its results are collected in issue order into vector_c.

module single_divide (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] c
);
  // Two register stages: operand capture, then rounded result.
  // Denormal operands and results are flushed to zero; NaN results are canonical.
  logic        s1_valid_q;
  logic [31:0] s1_a_q;
  logic [31:0] s1_b_q;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
  logic [49:0] num;
  logic [49:0] den;
  logic [26:0] quo;
  logic        rem_nz;
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [23:0] frac_r;
  logic [9:0]  exp_raw;
  logic [9:0]  exp_f;
  logic [31:0] res;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      out_valid  <= 1'b0;
      c          <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q <= a;
        s1_b_q <= b;
      end
      out_valid <= s1_valid_q;
      if (s1_valid_q) c <= res;
    end
  end

  assign a_zero = (s1_a_q[30:23] == 8'h00);
  assign b_zero = (s1_b_q[30:23] == 8'h00);
  assign a_inf  = (s1_a_q[30:23] == 8'hFF) && (s1_a_q[22:0] == 23'h0);
  assign b_inf  = (s1_b_q[30:23] == 8'hFF) && (s1_b_q[22:0] == 23'h0);
  assign a_nan  = (s1_a_q[30:23] == 8'hFF) && (s1_a_q[22:0] != 23'h0);
  assign b_nan  = (s1_b_q[30:23] == 8'hFF) && (s1_b_q[22:0] != 23'h0);
  assign sign   = s1_a_q[31] ^ s1_b_q[31];

  // Quotient of the two 24-bit significands lies in (2^25, 2^27).
  assign num    = {1'b1, s1_a_q[22:0], 26'b0};
  assign den    = {26'b0, 1'b1, s1_b_q[22:0]};
  assign quo    = 27'(num / den);
  assign rem_nz = (num % den) != '0;

  always_comb begin
    if (quo[26]) begin
      frac   = quo[25:3];
      guard  = quo[2];
      sticky = (|quo[1:0]) | rem_nz;
    end else begin
      frac   = quo[24:2];
      guard  = quo[1];
      sticky = quo[0] | rem_nz;
    end
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {23'b0, round_up};
    exp_raw  = {2'b00, s1_a_q[30:23]} - {2'b00, s1_b_q[30:23]}
             + (quo[26] ? 10'd127 : 10'd126);
    exp_f    = exp_raw + {9'b0, frac_r[23]};
    res      = {sign, exp_f[7:0], frac_r[22:0]};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res = 32'h7FC0_0000;
    end else if (a_inf || b_zero) begin
      res = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      res = {sign, 31'h0};
    end else if ($signed(exp_raw) <= 10'sd0) begin
      res = {sign, 31'h0};
    end else if ($signed(exp_f) >= 10'sd255) begin
      res = {sign, 8'hFF, 23'h0};
    end
  end
endmodule

module single_divide_s_v_serial #(
  parameter int unsigned WIDTH = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] vector_b [WIDTH],
  output logic        out_valid,
  output logic [31:0] vector_c [WIDTH]
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] issue_idx_q, issue_idx_d;
  logic [CW-1:0] res_idx_q, res_idx_d;
  logic [31:0] a_q;
  logic [31:0] b_q [WIDTH];
  logic        accept, res_we;
  logic        div_in_valid, div_out_valid;
  logic [31:0] div_b, div_c;

  assign div_b = div_in_valid ? b_q[issue_idx_q[IW-1:0]] : '0;

  single_divide u_div (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (div_in_valid),
    .a         (a_q),
    .b         (div_b),
    .out_valid (div_out_valid),
    .c         (div_c)
  );

  always_comb begin
    state_d      = state_q;
    issue_idx_d  = issue_idx_q;
    res_idx_d    = res_idx_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    div_in_valid = 1'b0;
    accept       = 1'b0;
    res_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept      = 1'b1;
          issue_idx_d = '0;
          res_idx_d   = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        div_in_valid = 1'b1;
        issue_idx_d  = issue_idx_q + CW'(1);
        if (issue_idx_q == CW'(WIDTH - 1)) state_d = StDrain;
      end
      StDrain: ;
      StDone: begin
        out_valid = 1'b1;
        state_d   = StIdle;
      end
    endcase
    // Results arrive in issue order; the count of them, not a latency, ends the run.
    if (div_out_valid && (state_q == StIssue || state_q == StDrain)
        && (res_idx_q < CW'(WIDTH))) begin
      res_we    = 1'b1;
      res_idx_d = res_idx_q + CW'(1);
      if (res_idx_q == CW'(WIDTH - 1)) state_d = StDone;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      issue_idx_q <= '0;
      res_idx_q   <= '0;
      a_q         <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        b_q[i]      <= '0;
        vector_c[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      res_idx_q   <= res_idx_d;
      if (accept) begin
        a_q <= a;
        b_q <= vector_b;
      end
      if (res_we) vector_c[res_idx_q[IW-1:0]] <= div_c;
    end
  end
endmodule

// File: tb/tb_single_divide_s_v_serial.sv
// Self-checking bench for single_divide_s_v_serial at WIDTH=4 and WIDTH=1, with a
// real-arithmetic reference for single-precision division (flush-to-zero, RNE).

module tb_single_divide_s_v_serial;
  localparam int W4    = 4;
  localparam int L_DIV = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        in_valid4, in_ready4, out_valid4;
  logic [31:0] a4;
  logic [31:0] b4 [W4];
  logic [31:0] c4 [W4];
  logic        in_valid1, in_ready1, out_valid1;
  logic [31:0] a1;
  logic [31:0] b1 [1];
  logic [31:0] c1 [1];

  int n_checks = 0;
  int n_fail   = 0;
  int lat, pulses, rdy_bad, div_cnt, div_runs;
  logic [31:0] cap [W4];

  single_divide_s_v_serial #(.WIDTH(W4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4),
    .vector_b(b4), .out_valid(out_valid4), .vector_c(c4)
  );

  single_divide_s_v_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1),
    .vector_b(b1), .out_valid(out_valid1), .vector_c(c1)
  );

  function automatic real to_real(input logic [31:0] x);
    logic [10:0] de;
    de = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({1'b0, de, x[22:0], 29'h0});
  endfunction

  // Quotient in double is exact enough that one rounding to single is correct.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic xz, yz, xi, yi, xn, yn, sgn, up;
    logic [63:0] qb;
    logic [23:0] fr;
    int e;
    xz  = (x[30:23] == 8'h00);
    yz  = (y[30:23] == 8'h00);
    xi  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xn  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    sgn = x[31] ^ y[31];
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC0_0000;
    if (xi || yz) return {sgn, 8'hFF, 23'h0};
    if (xz || yi) return {sgn, 31'h0};
    qb = $realtobits(to_real(x) / to_real(y));
    e  = int'(qb[62:52]) - 896;
    if (e <= 0) return {sgn, 31'h0};
    up = qb[28] && ((|qb[27:0]) || qb[29]);
    fr = {1'b0, qb[51:29]} + {23'h0, up};
    if (fr[23]) e = e + 1;
    if (e >= 255) return {sgn, 8'hFF, 23'h0};
    return {sgn, 8'(e), fr[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int unsigned k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:23] = 8'h00;
      4, 5: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  task automatic drive_req4(input logic [31:0] av);
    int t;
    t = 0;
    @(negedge clk);
    a4 = av;
    in_valid4 = 1'b1;
    while (!in_ready4 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready4) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready4);
    end
    @(posedge clk);
    #1 in_valid4 = 1'b0;
  endtask

  // Starts right after an accept edge; k counts cycles of the accepted request.
  task automatic watch4(input int cycles);
    logic prev_div;
    prev_div = 1'b0;
    lat = 0; pulses = 0; rdy_bad = 0; div_cnt = 0; div_runs = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (out_valid4) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          for (int i = 0; i < W4; i++) cap[i] = c4[i];
        end
      end
      if (in_ready4 && (lat == 0 || k <= lat)) rdy_bad++;
      if (dut4.div_in_valid) begin
        div_cnt++;
        if (!prev_div) div_runs++;
      end
      prev_div = dut4.div_in_valid;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready4); end
    n_checks++;
    if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid4); end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (c4[i] !== 32'h0) begin n_fail++; $display("FAIL reset_c[%0d]: got %h want 0", i, c4[i]); end
    end
    n_checks++;
    if (c1[0] !== 32'h0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w1: got c=%h rdy=%b ov=%b want 0/1/0", c1[0], in_ready1, out_valid1);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_c [W4];
    exp_c[0] = 32'h4080_0000; exp_c[1] = 32'h4000_0000;
    exp_c[2] = 32'h3F80_0000; exp_c[3] = 32'h4100_0000;
    b4[0] = 32'h3F80_0000; b4[1] = 32'h4000_0000; b4[2] = 32'h4080_0000; b4[3] = 32'h3F00_0000;
    drive_req4(32'h4080_0000);
    watch4(W4 + L_DIV + 6);
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
    n_checks++;
    if (lat !== W4 + L_DIV + 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, W4 + L_DIV + 1);
    end
    n_checks++;
    if (rdy_bad !== 0) begin n_fail++; $display("FAIL basic_in_ready_low: got %0d high cycles want 0", rdy_bad); end
    n_checks++;
    if (div_cnt !== W4 || div_runs !== 1) begin
      n_fail++; $display("FAIL basic_div_issue: got %0d cycles in %0d runs want 4 in 1", div_cnt, div_runs);
    end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (cap[i] !== exp_c[i]) begin n_fail++; $display("FAIL basic_c[%0d]: got %h want %h", i, cap[i], exp_c[i]); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [31:0] exp_c [W4];
    exp_c[0] = 32'h3F00_0000; exp_c[1] = 32'h3E80_0000;
    exp_c[2] = 32'h3E00_0000; exp_c[3] = 32'hBF80_0000;
    b4[0] = 32'h4000_0000; b4[1] = 32'h4080_0000; b4[2] = 32'h4100_0000; b4[3] = 32'hBF80_0000;
    drive_req4(32'h3F80_0000);
    @(negedge clk);
    in_valid4 = 1'b1;
    a4 = 32'h42C8_0000;
    for (int i = 0; i < W4; i++) b4[i] = 32'h3F80_0000;
    @(negedge clk);
    in_valid4 = 1'b0;
    watch4(W4 + L_DIV + 8);
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (cap[i] !== exp_c[i]) begin n_fail++; $display("FAIL ignore_c[%0d]: got %h want %h", i, cap[i], exp_c[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] first [W4];
    logic [31:0] fb [W4];
    int k1;
    int bad;
    fb[0] = 32'h3F80_0000; fb[1] = 32'h4000_0000; fb[2] = 32'h4080_0000; fb[3] = 32'h4040_0000;
    b4 = fb;
    drive_req4(32'h4000_0000);
    k1 = 0;
    for (int k = 1; k <= 20 && k1 == 0; k++) begin
      @(negedge clk);
      if (out_valid4) begin
        k1 = k;
        for (int i = 0; i < W4; i++) first[i] = c4[i];
      end
    end
    n_checks++;
    if (k1 !== W4 + L_DIV + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", k1, W4 + L_DIV + 1); end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (first[i] !== ref_div(32'h4000_0000, fb[i])) begin
        n_fail++; $display("FAIL b2b_first_c[%0d]: got %h want %h", i, first[i], ref_div(32'h4000_0000, fb[i]));
      end
    end
    a4 = 32'h3F80_0000;
    for (int i = 0; i < W4; i++) b4[i] = 32'h4000_0000;
    in_valid4 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_first_idle: got %b want 1", in_ready4); end
    bad = 0;
    for (int i = 0; i < W4; i++) if (c4[i] !== first[i]) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL b2b_first_held: got %0d changed elements want 0", bad); end
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    watch4(W4 + L_DIV + 4);
    n_checks++;
    if (pulses !== 1 || lat !== W4 + L_DIV + 1) begin
      n_fail++; $display("FAIL b2b_second_timing: got %0d pulses lat %0d want 1 lat %0d", pulses, lat, W4 + L_DIV + 1);
    end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (cap[i] !== 32'h3F00_0000) begin n_fail++; $display("FAIL b2b_second_c[%0d]: got %h want 3f000000", i, cap[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    logic [31:0] exp_c [W4];
    b4[0] = 32'h3F80_0000; b4[1] = 32'h4000_0000; b4[2] = 32'h4080_0000; b4[3] = 32'h3F00_0000;
    drive_req4(32'h4080_0000);
    repeat (W4 + 1) @(negedge clk);
    rstn = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < W4; i++) if (c4[i] !== 32'h0) bad++;
    n_checks++;
    if (bad !== 0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_reset: got %0d nonzero, ov=%b rdy=%b want 0/0/1", bad, out_valid4, in_ready4);
    end
    @(negedge clk);
    rstn = 1'b1;
    watch4(W4 + L_DIV + 6);
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_out_valid: got %0d pulses want 0", pulses); end
    bad = 0;
    for (int i = 0; i < W4; i++) if (c4[i] !== 32'h0) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL abort_no_stale_write: got %0d nonzero want 0", bad); end
    exp_c[0] = 32'h3F80_0000; exp_c[1] = 32'h4000_0000;
    exp_c[2] = 32'hBF80_0000; exp_c[3] = 32'h3F00_0000;
    b4[0] = 32'h4040_0000; b4[1] = 32'h3FC0_0000; b4[2] = 32'hC040_0000; b4[3] = 32'h40C0_0000;
    drive_req4(32'h4040_0000);
    watch4(W4 + L_DIV + 4);
    n_checks++;
    if (pulses !== 1 || lat !== W4 + L_DIV + 1) begin
      n_fail++; $display("FAIL abort_next_timing: got %0d pulses lat %0d want 1 lat %0d", pulses, lat, W4 + L_DIV + 1);
    end
    for (int i = 0; i < W4; i++) begin
      n_checks++;
      if (cap[i] !== exp_c[i]) begin n_fail++; $display("FAIL abort_next_c[%0d]: got %h want %h", i, cap[i], exp_c[i]); end
    end
  endtask

  task automatic run_w1(input logic [31:0] av, input logic [31:0] bv, output int p1, output int l1,
                        output logic [31:0] r1);
    int t;
    @(negedge clk);
    a1 = av;
    b1[0] = bv;
    in_valid1 = 1'b1;
    t = 0;
    while (!in_ready1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    a1 = $urandom;
    b1[0] = $urandom;
    p1 = 0; l1 = 0; r1 = 32'h0;
    for (int k = 1; k <= 1 + L_DIV + 4; k++) begin
      @(negedge clk);
      if (out_valid1) begin
        p1++;
        if (l1 == 0) begin l1 = k; r1 = c1[0]; end
      end
    end
  endtask

  task automatic test_width1();
    int p1, l1;
    logic [31:0] r1, av, bv;
    run_w1(32'h4040_0000, 32'h0000_0000, p1, l1, r1);
    n_checks++;
    if (p1 !== 1 || l1 !== 1 + L_DIV + 1) begin
      n_fail++; $display("FAIL w1_timing: got %0d pulses lat %0d want 1 lat %0d", p1, l1, 1 + L_DIV + 1);
    end
    n_checks++;
    if (r1 !== 32'h7F80_0000) begin n_fail++; $display("FAIL w1_div_by_zero: got %h want 7f800000", r1); end
    for (int n = 0; n < 6; n++) begin
      av = rand_fp();
      bv = rand_fp();
      run_w1(av, bv, p1, l1, r1);
      n_checks++;
      if (p1 !== 1 || r1 !== ref_div(av, bv)) begin
        n_fail++; $display("FAIL w1_random %h/%h: got %h (%0d pulses) want %h", av, bv, r1, p1, ref_div(av, bv));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb [W4];
    for (int n = 0; n < 12; n++) begin
      ra = rand_fp();
      for (int i = 0; i < W4; i++) rb[i] = rand_fp();
      b4 = rb;
      drive_req4(ra);
      a4 = $urandom;
      for (int i = 0; i < W4; i++) b4[i] = $urandom;
      watch4(W4 + L_DIV + 3);
      n_checks++;
      if (pulses !== 1 || lat !== W4 + L_DIV + 1) begin
        n_fail++; $display("FAIL rand_timing[%0d]: got %0d pulses lat %0d want 1 lat %0d", n, pulses, lat, W4 + L_DIV + 1);
      end
      for (int i = 0; i < W4; i++) begin
        n_checks++;
        if (cap[i] !== ref_div(ra, rb[i])) begin
          n_fail++; $display("FAIL rand_c[%0d][%0d] %h/%h: got %h want %h", n, i, ra, rb[i], cap[i], ref_div(ra, rb[i]));
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    in_valid4 = 1'b0; in_valid1 = 1'b0;
    a4 = '0; a1 = '0; b1[0] = '0;
    for (int i = 0; i < W4; i++) b4[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    test_basic();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
